// File: rtl/cordic_cos_core.sv
// Iterative CORDIC rotation engine: cos(theta) for theta in [0, 1] rad, Q1.20 in and out.
// One micro-rotation per enabled cycle; start/done handshake gated by clk_en.
module cordic_cos_core #(
  parameter int unsigned ITERATIONS = 16,
  parameter int unsigned IW         = 24
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [20:0] dataa,
  output logic [20:0] result,
  output logic        done
);

  localparam int unsigned CW = 5;

  localparam logic signed [IW-1:0] K_INIT = IW'(32'sh0009_B74F);
  localparam logic signed [IW-1:0] ONE_IW = IW'(32'sh0010_0000);
  localparam logic        [20:0]   ONE_Q  = 21'h10_0000;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FINISH
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic signed [IW-1:0] r_x;
  logic signed [IW-1:0] r_y;
  logic signed [IW-1:0] r_z;
  logic        [CW-1:0] r_i;
  logic        [20:0]   r_result;
  logic                 r_done;

  logic                 w_accept;
  logic                 w_iter;
  logic                 w_finish;
  logic        [20:0]   w_angle;
  logic signed [IW-1:0] w_z_load;
  logic signed [IW-1:0] w_x_sh;
  logic signed [IW-1:0] w_y_sh;
  logic signed [IW-1:0] w_atan;
  logic signed [IW-1:0] w_x_rot;
  logic signed [IW-1:0] w_y_rot;
  logic signed [IW-1:0] w_z_rot;
  logic        [20:0]   w_sat;

  // round(atan(2^-i) * 2^20) for i = 0..19
  function automatic logic signed [IW-1:0] atan_entry(input logic [CW-1:0] idx);
    logic [20:0] v;
    case (idx)
      5'd0:    v = 21'h0C_90FE;
      5'd1:    v = 21'h07_6B1A;
      5'd2:    v = 21'h03_EB6F;
      5'd3:    v = 21'h01_FD5C;
      5'd4:    v = 21'h00_FFAB;
      5'd5:    v = 21'h00_7FF5;
      5'd6:    v = 21'h00_3FFF;
      5'd7:    v = 21'h00_2000;
      5'd8:    v = 21'h00_1000;
      5'd9:    v = 21'h00_0800;
      5'd10:   v = 21'h00_0400;
      5'd11:   v = 21'h00_0200;
      5'd12:   v = 21'h00_0100;
      5'd13:   v = 21'h00_0080;
      5'd14:   v = 21'h00_0040;
      5'd15:   v = 21'h00_0020;
      5'd16:   v = 21'h00_0010;
      5'd17:   v = 21'h00_0008;
      5'd18:   v = 21'h00_0004;
      5'd19:   v = 21'h00_0002;
      default: v = '0;
    endcase
    return $signed({{(IW-21){1'b0}}, v});
  endfunction

  // State register: reset overrides clk_en, clk_en low freezes the FSM
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else if (clk_en) begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = ITER;
      ITER:    if (r_i == CW'(ITERATIONS - 1)) w_state_nxt = FINISH;
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output/control decode plus the combinational rotation and saturation datapath
  always_comb begin
    w_accept = (r_state == IDLE) && start;
    w_iter   = (r_state == ITER);
    w_finish = (r_state == FINISH);

    w_angle  = (dataa > ONE_Q) ? ONE_Q : dataa;
    w_z_load = $signed({{(IW-21){1'b0}}, w_angle});

    w_x_sh = r_x >>> r_i;
    w_y_sh = r_y >>> r_i;
    w_atan = atan_entry(r_i);

    if (!r_z[IW-1]) begin
      w_x_rot = r_x - w_y_sh;
      w_y_rot = r_y + w_x_sh;
      w_z_rot = r_z - w_atan;
    end else begin
      w_x_rot = r_x + w_y_sh;
      w_y_rot = r_y - w_x_sh;
      w_z_rot = r_z + w_atan;
    end

    if (r_x[IW-1]) begin
      w_sat = '0;
    end else if (r_x > ONE_IW) begin
      w_sat = ONE_Q;
    end else begin
      w_sat = r_x[20:0];
    end
  end

  // Datapath and iteration counter: load on accept, rotate while iterating
  always_ff @(posedge clock) begin
    if (reset) begin
      r_x <= '0;
      r_y <= '0;
      r_z <= '0;
      r_i <= '0;
    end else if (clk_en) begin
      if (w_accept) begin
        r_x <= K_INIT;
        r_y <= '0;
        r_z <= w_z_load;
        r_i <= '0;
      end else if (w_iter) begin
        r_x <= w_x_rot;
        r_y <= w_y_rot;
        r_z <= w_z_rot;
        r_i <= r_i + CW'(1);
      end
    end
  end

  // Result capture and one-cycle done pulse, both leaving FINISH together
  always_ff @(posedge clock) begin
    if (reset) begin
      r_result <= '0;
      r_done   <= 1'b0;
    end else if (clk_en) begin
      r_done <= w_finish;
      if (w_finish) begin
        r_result <= w_sat;
      end
    end
  end

  assign result = r_result;
  assign done   = r_done;

endmodule

// File: tb/tb_cordic_cos_core.sv
// Scoreboard bench for cordic_cos_core: stimulus pushes expected windows, monitor pops on done.
module tb_cordic_cos_core;

  logic        clock;
  logic        reset;
  logic        clk_en;
  logic        start;
  logic [20:0] dataa;
  logic [20:0] result;
  logic        done;

  cordic_cos_core #(
    .ITERATIONS(16),
    .IW        (24)
  ) dut (
    .clock (clock),
    .reset (reset),
    .clk_en(clk_en),
    .start (start),
    .dataa (dataa),
    .result(result),
    .done  (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [20:0] lo;
    logic [20:0] hi;
    int          exp_cyc;
    int          tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc        = 0;
  logic en_at_edge = 1'b0;
  int   n_checks   = 0;
  int   n_errors   = 0;

  always @(posedge clock) begin
    cyc        <= cyc + 1;
    en_at_edge <= clk_en;
  end

  // Monitor: a fresh done (produced by an enabled edge) must match the oldest expectation
  always @(negedge clock) begin
    if (!reset && done === 1'b1 && en_at_edge) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL spurious_done: done=1 result=%h at cycle %0d, required no done", result, cyc);
      end else begin
        mon_e = sb.pop_front();
        n_checks += 2;
        if (result < mon_e.lo || result > mon_e.hi) begin
          n_errors++;
          $display("FAIL result_op%0d: got %h, required %h..%h", mon_e.tag, result, mon_e.lo, mon_e.hi);
        end
        if (cyc != mon_e.exp_cyc) begin
          n_errors++;
          $display("FAIL latency_op%0d: done at cycle %0d, required cycle %0d", mon_e.tag, cyc, mon_e.exp_cyc);
        end
      end
    end
  end

  task automatic check_eq(input string nm, input logic [20:0] got, input logic [20:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", nm, got, want);
    end
  endtask

  task automatic wait_drain(input int tag);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 80) begin
      @(negedge clock);
      k++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL done_timeout_op%0d: %0d results pending, required 0", tag, sb.size());
      sb.delete();
    end
  endtask

  task automatic run_op(input logic [20:0] a, input int center, input int tol_lo,
                        input int tol_hi, input int tag);
    exp_t e;
    @(negedge clock);
    e.lo      = 21'(center - tol_lo);
    e.hi      = 21'(center + tol_hi);
    e.exp_cyc = cyc + 18;
    e.tag     = tag;
    sb.push_back(e);
    start = 1'b1;
    dataa = a;
    @(negedge clock);
    start = 1'b0;
    wait_drain(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    reset  = 1'b1;
    clk_en = 1'b1;
    start  = 1'b1;
    dataa  = 21'h08_0000;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    start = 1'b0;
    check_eq("reset_result", result, 21'h0);
    check_eq("reset_done", {20'h0, done}, 21'h0);
    repeat (25) @(negedge clock);

    // Directed angles with hand-computed round(cos(theta) * 2^20)
    run_op(21'h00_0000, 32'h10_0000, 16, 0,  1);
    run_op(21'h08_0000, 32'h0E_0A94, 16, 16, 2);
    run_op(21'h10_0000, 32'h08_A514, 16, 16, 3);
    run_op(21'h1F_FFFF, 32'h08_A514, 16, 16, 4);
    run_op(21'h0C_DCCD, 32'h0B_1A36, 16, 16, 5);
    run_op(21'h06_9666, 32'h0E_A9B7, 16, 16, 6);
    run_op(21'h00_5000, 32'h0F_FF38, 16, 16, 7);

    // Stall of 5 cycles mid-ITER, a colliding start, and dataa changed after acceptance
    @(negedge clock);
    e.lo      = 21'h0E_0A94 - 21'd16;
    e.hi      = 21'h0E_0A94 + 21'd16;
    e.exp_cyc = cyc + 18 + 5;
    e.tag     = 8;
    sb.push_back(e);
    start = 1'b1;
    dataa = 21'h08_0000;
    @(negedge clock);
    start = 1'b0;
    dataa = 21'h1F_FFFF;
    repeat (4) @(negedge clock);
    start = 1'b1;
    dataa = 21'h00_0000;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    clk_en = 1'b0;
    repeat (5) @(negedge clock);
    clk_en = 1'b1;
    wait_drain(8);
    repeat (25) @(negedge clock);

    // Reset at iteration 8 aborts the operation: no done, result cleared
    @(negedge clock);
    start = 1'b1;
    dataa = 21'h10_0000;
    @(negedge clock);
    start = 1'b0;
    repeat (8) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_eq("abort_result", result, 21'h0);
    check_eq("abort_done", {20'h0, done}, 21'h0);
    repeat (25) @(negedge clock);

    run_op(21'h06_9666, 32'h0E_A9B7, 16, 16, 10);

    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_empty: %0d entries left, required 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
